accum_lanes: RTL and testbench
==============================

Name: accum_lanes

Overview:
- Multi-lane successor accumulator for the MVM output path.
- Sums LANES partial results per address across the subset vectors of one input vector.
- Adds ready/valid backpressure on both sides and read-after-write bypass, so back-to-back updates to one address are legal.
- Sits between the DPE reduction outputs and the activation/writeback stage.

Parameters:
- LANES, 4, independent accumulation lanes sharing address/control.
- DATAW, 32, per-lane data width, signed two's complement.
- DEPTH, 512, accumulator entries per lane.
- ADDRW, $clog2(DEPTH), address width.
- OFIFO_DEPTH, 8, output queue entries; minimum 4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input beat valid.
- i_ready  out  1  input beat accepted when i_valid && i_ready.
- i_data  in  LANES*DATAW  lane k at bits [k*DATAW +: DATAW].
- i_addr  in  ADDRW  accumulator entry.
- i_accum  in  1  1 = add to stored value; 0 = overwrite (first subset).
- i_last  in  1  final subset; result is emitted.
- o_valid  out  1  output queue head valid.
- o_ready  in  1  consumer accepts head.
- o_result  out  LANES*DATAW  accumulated result, same lane packing.
- o_addr  out  ADDRW  address of the emitted result.

Behaviour:
- Acceptance at cycle T: memory read issued at T; memory_block read latency is 2 cycles.
- Sum formed at T+2, registered at T+3; memory write commits at T+3 with wen registered.
- Operand when i_accum=1 is the newest value of that address, including beats accepted 1, 2 or 3 cycles earlier.
  - Implemented as an address-compare bypass, priority youngest first: T+3 result register, then committing write, then memory data.
  - No bubbles are required between same-address beats.
- i_accum=0 stores i_data unchanged; the stored value is ignored.
- Arithmetic: per-lane add, wraps modulo 2^DATAW; no carry between lanes.
- i_last=1: the committed result and address are pushed into the output queue at T+3.
  - Queue is show-ahead; first-word o_valid at T+4.
  - Head pops on o_valid && o_ready.
  - Queue order equals acceptance order.
- i_ready = (OFIFO_DEPTH - queue_count - inflight_last) > 0, where inflight_last counts accepted i_last beats not yet pushed.
  - The queue never overflows; beats without i_last still need i_ready.
- Simultaneous push and pop with a full queue is legal; count is unchanged.
- Non-last beats never produce output. i_last with i_accum=0 emits i_data.
- Reset values: i_ready=0 during rst, 1 the cycle after; o_valid=0; o_result=0; o_addr=0. Pipeline valids, bypass state, inflight_last and queue are all cleared.
- Reset mid-operation: in-flight beats are dropped; a write not yet committed does not occur. Memory contents are not cleared and are undefined after reset, so the first beat per address must use i_accum=0.
- Beats presented while i_ready=0 are ignored; the source holds them.

Optional Feature:
- ACCUM_SAT_EN defined:
  - Per-lane signed saturating add, clamping to 2^(DATAW-1)-1 or -2^(DATAW-1).
  - Extra output o_sat [LANES-1:0] travels with each queue entry; a bit is set if that lane saturated on any beat of the vector since its i_accum=0 beat.
  - Sticky flags are stored alongside memory entries.
- Undefined: wrapping add; no o_sat port; no flag storage.

Decomposition:
- Package accum_pkg:
  - constants MEM_RD_LAT=2 and PIPE_DEPTH=3;
  - typedef for the lane vector;
  - function sat_add(a, b) used under ACCUM_SAT_EN.
- Memory: one memory_block instance of width LANES*DATAW (plus LANES flag bits under ACCUM_SAT_EN).
- Sub-module accum_out_fifo: show-ahead FIFO of result+addr(+sat) with count output.

Test Plan:
- Overwrite then accumulate: addr 5, lane0 data 10 (accum=0), then 7 (accum=1, last=1) on consecutive cycles -> one output, lane0=17, o_addr=5, o_valid 4 cycles after the second beat.
- Hazard chain: four back-to-back beats to addr 3, lane data 1,2,3,4, first accum=0, last on the fourth -> result 10 on every lane; repeat with one idle cycle between beats -> same.
- Interleave: addr 0 and 1 alternating, 3 subsets each, values 100/200 per subset -> outputs 300 then 600 in acceptance order.
- Backpressure: o_ready=0, stream 12 last beats to distinct addresses -> i_ready falls after 8 queued/in-flight; release o_ready -> all 12 outputs, none lost or duplicated.
- Wrap/sat: lane0 0x7FFFFFFF + 1 -> 0x80000000 without ACCUM_SAT_EN; 0x7FFFFFFF with o_sat[0]=1 when defined.
- Reset mid-stream: assert rst one cycle after a last beat -> no output ever appears; o_valid=0, i_ready=0 during rst, 1 after.

Source files
------------

// File: rtl/accum_pkg.sv
// accum_pkg: shared constants, lane vector type and the saturating
// lane add used by the accum_lanes accumulator.
package accum_pkg;

    localparam int MEM_RD_LAT = 2;
    localparam int PIPE_DEPTH = 3;
    localparam int LANES      = 4;
    localparam int DATAW      = 32;
    localparam int VECW       = LANES * DATAW;

    typedef logic [LANES-1:0][DATAW-1:0] lane_vec_t;

    // Returns {overflow, clamped signed sum}.
    function automatic logic [DATAW:0] sat_add(
        input logic [DATAW-1:0] a,
        input logic [DATAW-1:0] b
    );
        logic [DATAW-1:0] sum;
        logic             ovf;
        sum = a + b;
        ovf = (a[DATAW-1] == b[DATAW-1]) && (sum[DATAW-1] != a[DATAW-1]);
        if (ovf)
            sum = a[DATAW-1] ? {1'b1, {(DATAW-1){1'b0}}}
                             : {1'b0, {(DATAW-1){1'b1}}};
        return {ovf, sum};
    endfunction

endpackage

// File: rtl/accum_out_fifo.sv
// accum_out_fifo: show-ahead result queue. Ports: clk, rst (sync, high),
// push/wdata, pop, rdata (head), valid, count.
module accum_out_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 wdata,
    input  logic                         pop,
    output logic [W-1:0]                 rdata,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic          pop_ok;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid  = (count != '0);
    assign rdata  = mem[rp];
    assign pop_ok = pop && valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push)
                wp <= inc(wp);
            if (pop_ok)
                rp <= inc(rp);
            count <= count + CW'(push) - CW'(pop_ok);
        end
        // With a full queue the written slot is the head being popped.
        if (push)
            mem[wp] <= wdata;
    end

endmodule

// File: rtl/memory_block.sv
// memory_block: simple dual-port RAM, registered read address plus
// LAT-1 output stages. Ports: clk, raddr/rdata, wen/waddr/wdata.
module memory_block #(
    parameter int W     = 32,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH),
    parameter int LAT   = 2
) (
    input  logic          clk,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata
);

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  pipe [LAT-1];
    logic [AW-1:0] raddr_q;

    always_ff @(posedge clk) begin
        raddr_q <= raddr;
        pipe[0] <= mem[raddr_q];
        for (int i = 1; i < LAT - 1; i++)
            pipe[i] <= pipe[i-1];
        if (wen)
            mem[waddr] <= wdata;
    end

    assign rdata = pipe[LAT-2];

endmodule

// File: rtl/accum_lanes.sv
// accum_lanes: multi-lane per-address accumulator with read-after-write
// bypass, ready/valid on both sides and an in-order output queue.
// Ports: clk, rst (sync, high); i_valid, i_ready, i_data, i_addr,
// i_accum, i_last; o_valid, o_ready, o_result, o_addr.
// Build option ACCUM_SAT_EN: saturating add plus sticky o_sat flags.
module accum_lanes
    import accum_pkg::*;
#(
    parameter int DEPTH       = 512,
    parameter int ADDRW       = $clog2(DEPTH),
    parameter int OFIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [VECW-1:0]  i_data,
    input  logic [ADDRW-1:0] i_addr,
    input  logic             i_accum,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [VECW-1:0]  o_result,
`ifdef ACCUM_SAT_EN
    output logic [LANES-1:0] o_sat,
`endif
    output logic [ADDRW-1:0] o_addr
);

`ifdef ACCUM_SAT_EN
    localparam int MEMW = VECW + LANES;
`else
    localparam int MEMW = VECW;
`endif
    localparam int QW   = MEMW + ADDRW;
    localparam int CNTW = $clog2(OFIFO_DEPTH + 1);
    localparam int INFW = $clog2(PIPE_DEPTH + 1);

    logic             accept, wen, push, pop;
    logic             v1, acc1, last1;
    logic             v2, acc2, last2;
    logic             v3, last3, cv;
    logic [ADDRW-1:0] a1, a2, a3, ca;
    logic [VECW-1:0]  d1, d2;
    logic [MEMW-1:0]  w3, cw, rdata, old_w, new_w;
    logic [QW-1:0]    head;
    logic [CNTW-1:0]  count;
    logic [INFW-1:0]  inflight;
    lane_vec_t        dv, ov, sv;
`ifdef ACCUM_SAT_EN
    logic [LANES-1:0] fl;
    logic [DATAW:0]   t;
`endif

    // Last beats already accepted but not yet in the queue.
    assign inflight = INFW'(v1 && last1) + INFW'(v2 && last2)
                    + INFW'(v3 && last3);
    assign i_ready  = !rst
                   && ((int'(count) + int'(inflight)) < OFIFO_DEPTH);
    assign accept   = i_valid && i_ready;
    assign wen      = v3 && !rst;
    assign push     = v3 && last3 && !rst;
    assign pop      = o_valid && o_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            cv <= 1'b0;
        end else begin
            v1 <= accept;
            v2 <= v1;
            v3 <= v2;
            cv <= v3;
        end
        a1    <= i_addr;
        d1    <= i_data;
        acc1  <= i_accum;
        last1 <= i_last;
        a2    <= a1;
        d2    <= d1;
        acc2  <= acc1;
        last2 <= last1;
        a3    <= a2;
        last3 <= last2;
        w3    <= new_w;
        ca    <= a3;
        cw    <= w3;
    end

    // RAM data misses the two youngest writes; youngest match wins.
    always_comb begin
        old_w = rdata;
        if (cv && ca == a2)
            old_w = cw;
        if (v3 && a3 == a2)
            old_w = w3;
    end

    always_comb begin
        dv = d2;
        ov = old_w[VECW-1:0];
        sv = dv;
`ifdef ACCUM_SAT_EN
        fl = '0;
        t  = '0;
`endif
        if (acc2) begin
            for (int k = 0; k < LANES; k++) begin
`ifdef ACCUM_SAT_EN
                t     = sat_add(ov[k], dv[k]);
                sv[k] = t[DATAW-1:0];
                fl[k] = old_w[VECW + k] | t[DATAW];
`else
                sv[k] = ov[k] + dv[k];
`endif
            end
        end
`ifdef ACCUM_SAT_EN
        new_w = {fl, sv};
`else
        new_w = sv;
`endif
    end

    memory_block #(
        .W     (MEMW),
        .DEPTH (DEPTH),
        .AW    (ADDRW),
        .LAT   (MEM_RD_LAT)
    ) u_mem (
        .clk   (clk),
        .raddr (i_addr),
        .rdata (rdata),
        .wen   (wen),
        .waddr (a3),
        .wdata (w3)
    );

    accum_out_fifo #(
        .W     (QW),
        .DEPTH (OFIFO_DEPTH)
    ) u_ofifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({w3, a3}),
        .pop   (pop),
        .rdata (head),
        .valid (o_valid),
        .count (count)
    );

    assign o_addr   = o_valid ? head[ADDRW-1:0] : '0;
    assign o_result = o_valid ? head[ADDRW +: VECW] : '0;
`ifdef ACCUM_SAT_EN
    assign o_sat    = o_valid ? head[QW-1 -: LANES] : '0;
`endif

endmodule

// File: tb/tb_accum_lanes.sv
// tb_accum_lanes: directed stimulus for accum_lanes; a reference model
// queues expected results that are compared as outputs are consumed.
module tb_accum_lanes;
    import accum_pkg::*;

    localparam int DEPTH = 512;
    localparam int ADDRW = 9;

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [VECW-1:0]  res;
        logic [LANES-1:0] sat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_valid = 1'b0;
    logic             i_ready;
    logic [VECW-1:0]  i_data = '0;
    logic [ADDRW-1:0] i_addr = '0;
    logic             i_accum = 1'b0;
    logic             i_last = 1'b0;
    logic             o_valid;
    logic             o_ready = 1'b1;
    logic [VECW-1:0]  o_result;
    logic [ADDRW-1:0] o_addr;
`ifdef ACCUM_SAT_EN
    logic [LANES-1:0] o_sat;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t sbq[$];
    logic [VECW-1:0]  mdl [DEPTH];
    logic [LANES-1:0] mflag [DEPTH];

    accum_lanes dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .i_data   (i_data),
        .i_addr   (i_addr),
        .i_accum  (i_accum),
        .i_last   (i_last),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_result (o_result),
`ifdef ACCUM_SAT_EN
        .o_sat    (o_sat),
`endif
        .o_addr   (o_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [VECW-1:0] obs,
                       input logic [VECW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VECW-1:0] lanes(input logic [31:0] a,
        input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    task automatic model(input logic [ADDRW-1:0] a,
                         input logic [VECW-1:0] d,
                         input logic acc, input logic last);
        for (int k = 0; k < LANES; k++) begin
            logic [DATAW-1:0] o, x, n;
            logic f;
            o = mdl[a][k*DATAW +: DATAW];
            x = d[k*DATAW +: DATAW];
            n = x;
            f = 1'b0;
            if (acc) begin
                n = o + x;
                f = mflag[a][k];
`ifdef ACCUM_SAT_EN
                begin
                    longint s;
                    s = longint'($signed(o)) + longint'($signed(x));
                    if (s > 64'sd2147483647) begin
                        n = 32'h7fff_ffff;
                        f = 1'b1;
                    end else if (s < -64'sd2147483648) begin
                        n = 32'h8000_0000;
                        f = 1'b1;
                    end
                end
`endif
            end
            mdl[a][k*DATAW +: DATAW] = n;
            mflag[a][k] = f;
        end
        if (last)
            sbq.push_back('{addr: a, res: mdl[a], sat: mflag[a]});
    endtask

    task automatic beat(input int a, input logic [VECW-1:0] d,
                        input logic acc, input logic last);
        int n = 0;
        i_valid = 1'b1;
        i_addr  = ADDRW'(a);
        i_data  = d;
        i_accum = acc;
        i_last  = last;
        @(negedge clk);
        while (!i_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $error("FAIL accept_timeout observed=stalled expected=accepted");
        end
        @(posedge clk);
        #1;
        model(ADDRW'(a), d, acc, last);
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_left", VECW'(sbq.size()), '0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && o_valid && o_ready) begin
            checks++;
            assert (sbq.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_output observed=addr%0d expected=none",
                       o_addr);
            end
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk("o_result", o_result, e.res);
                chk("o_addr", VECW'(o_addr), VECW'(e.addr));
`ifdef ACCUM_SAT_EN
                chk("o_sat", VECW'(o_sat), VECW'(e.sat));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n;
        logic [VECW-1:0] r;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_i_ready", VECW'(i_ready), '0);
        chk("rst_o_valid", VECW'(o_valid), '0);
        chk("rst_o_result", o_result, '0);
        chk("rst_o_addr", VECW'(o_addr), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_i_ready", VECW'(i_ready), VECW'(1));
        @(posedge clk);
        #1;

        beat(5, lanes(10, 0, 0, 0), 1'b0, 1'b0);
        beat(5, lanes(7, 0, 0, 0), 1'b1, 1'b1);
        chk("first_result_model", mdl[5], lanes(17, 0, 0, 0));
        t0 = cyc;
        n = 0;
        @(negedge clk);
        while (!o_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", VECW'(cyc - t0), VECW'(3));
        drain();

        for (int i = 1; i <= 4; i++)
            beat(3, lanes(i, i, i, i), i != 1, i == 4);
        drain();
        for (int i = 1; i <= 4; i++) begin
            beat(3, lanes(i, i, i, i), i != 1, i == 4);
            @(posedge clk);
            #1;
        end
        drain();

        for (int s = 0; s < 3; s++) begin
            beat(0, lanes(100, 100, 100, 100), s != 0, s == 2);
            beat(1, lanes(200, 200, 200, 200), s != 0, s == 2);
        end
        drain();

        o_ready = 1'b0;
        for (int j = 0; j < 8; j++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            beat(20 + j, r, 1'b0, 1'b1);
        end
        @(negedge clk);
        chk("bp_ready_low", VECW'(i_ready), '0);
        i_valid = 1'b1;
        i_last  = 1'b1;
        repeat (6) @(negedge clk);
        chk("bp_still_low", VECW'(i_ready), '0);
        chk("bp_head_valid", VECW'(o_valid), VECW'(1));
        i_valid = 1'b0;
        o_ready = 1'b1;
        for (int j = 8; j < 12; j++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            beat(20 + j, r, 1'b0, 1'b1);
        end
        drain();

        beat(40, lanes(32'h7fff_ffff, 32'h8000_0000, 5, 0), 1'b0, 1'b0);
        beat(40, lanes(1, 32'hffff_ffff, 32'hffff_fffd, 0), 1'b1, 1'b1);
        beat(41, lanes(32'h7fff_fff0, 9, 0, 0), 1'b0, 1'b0);
        beat(41, lanes(32'h20, 1, 0, 0), 1'b1, 1'b0);
        beat(41, lanes(32'hffff_fffb, 1, 0, 0), 1'b1, 1'b1);
        drain();

        beat(50, lanes(9, 9, 9, 9), 1'b0, 1'b1);
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        chk("mid_rst_i_ready", VECW'(i_ready), '0);
        chk("mid_rst_o_valid", VECW'(o_valid), '0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_rst_o_valid2", VECW'(o_valid), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_i_ready", VECW'(i_ready), VECW'(1));
        repeat (10) @(negedge clk);
        chk("no_output_after_rst", VECW'(o_valid), '0);
        @(posedge clk);
        #1;

        beat(5, lanes(1, 2, 3, 4), 1'b0, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
